// File: rtl/pe_pkg.sv
// Shared constants, state encoding and config-size helpers for the PE loader/control blocks.
package pe_pkg;

   localparam int unsigned DATA_W      = 16;
   localparam int unsigned FSPAD_DEPTH = 224;
   localparam int unsigned ISPAD_DEPTH = 12;
   localparam int unsigned FADDR_W     = 8;
   localparam int unsigned IADDR_W     = 4;
   localparam int unsigned CFG_W       = 5;
   localparam int unsigned F_TOT_W     = 15;
   localparam int unsigned I_TOT_W     = 10;
   localparam int unsigned WDOG_CYC    = 4096;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_F = 3'd1,
      S_LOAD_I = 3'd2,
      S_FLUSH  = 3'd3,
      S_START  = 3'd4,
      S_RUN    = 3'd5,
      S_DONE   = 3'd6
   } state_e;

   // Widths are sized so that 31*31*31 and 31*31 never truncate.
   function automatic logic [F_TOT_W-1:0] calc_f_tot(input logic [CFG_W-1:0] fw,
                                                     input logic [CFG_W-1:0] oc,
                                                     input logic [CFG_W-1:0] ic);
      return F_TOT_W'(fw) * F_TOT_W'(oc) * F_TOT_W'(ic);
   endfunction

   function automatic logic [I_TOT_W-1:0] calc_i_tot(input logic [CFG_W-1:0] fw,
                                                     input logic [CFG_W-1:0] ic);
      return I_TOT_W'(fw) * I_TOT_W'(ic);
   endfunction

endpackage

// File: rtl/spad_write_port.sv
// Registered beat -> spad write stage with address counter and terminal-count flag.
module spad_write_port #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned TOT_W  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              beat,
   input  logic [TOT_W-1:0]  total,
   input  logic [DATA_W-1:0] wdata_in,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              last_c
);
   import pe_pkg::*;

   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   always_comb begin
      cnt_d   = cnt_q;
      we_d    = beat;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      last_c  = beat && (TOT_W'(cnt_q) == (total - TOT_W'(1)));
      if (beat) begin
         addr_d  = cnt_q;
         wdata_d = wdata_in;
         cnt_d   = last_c ? '0 : cnt_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign we    = we_q;
   assign addr  = addr_q;
   assign wdata = wdata_q;

endmodule

// File: rtl/pe_spad_loader.sv
// Per-PE loader: fills filter/ifmap scratchpads from the global buffer, then
// runs the PE via load/start/complete and reports done or err.
module pe_spad_loader #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned FSPAD_DEPTH = 224,
   parameter int unsigned ISPAD_DEPTH = 12,
   parameter int unsigned FADDR_W     = 8,
   parameter int unsigned IADDR_W     = 4,
   parameter int unsigned WDOG_CYC    = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_go,
   input  logic [4:0]         oc,
   input  logic [4:0]         ic,
   input  logic [4:0]         filter_width,
   input  logic [DATA_W-1:0]  gb_data,
   input  logic               gb_valid,
   output logic               gb_ready,
   output logic               fspad_we,
   output logic [FADDR_W-1:0] fspad_addr,
   output logic [DATA_W-1:0]  fspad_wdata,
   output logic               ispad_we,
   output logic [IADDR_W-1:0] ispad_addr,
   output logic [DATA_W-1:0]  ispad_wdata,
   output logic               load,
   output logic               start,
   input  logic               complete,
   output logic               busy,
   output logic               done,
   output logic               err
);
   import pe_pkg::*;

   localparam int unsigned WDOG_W = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;

   state_e             state_q, state_d;
   logic [CFG_W-1:0]   oc_q, oc_d, ic_q, ic_d, fw_q, fw_d;
   logic               gb_ready_q, gb_ready_d;
   logic               load_q, load_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               complete_q, complete_d;
   logic [WDOG_W-1:0]  wdog_q, wdog_d;

   logic [F_TOT_W-1:0] f_tot_c;
   logic [I_TOT_W-1:0] i_tot_c;
   logic               cfg_ok_c, beat_f_c, beat_i_c, last_f_c, last_i_c, cplt_edge_c;

   // Validation uses the live inputs; the fill counts use the latched fields.
   always_comb begin
      cfg_ok_c = (oc != '0) && (ic != '0) && (filter_width != '0) &&
                 (calc_f_tot(filter_width, oc, ic) <= F_TOT_W'(FSPAD_DEPTH)) &&
                 (calc_i_tot(filter_width, ic) <= I_TOT_W'(ISPAD_DEPTH));
      f_tot_c     = calc_f_tot(fw_q, oc_q, ic_q);
      i_tot_c     = calc_i_tot(fw_q, ic_q);
      beat_f_c    = gb_valid && gb_ready_q && (state_q == S_LOAD_F);
      beat_i_c    = gb_valid && gb_ready_q && (state_q == S_LOAD_I);
      cplt_edge_c = complete && !complete_q;
   end

   spad_write_port #(.DATA_W(DATA_W), .ADDR_W(FADDR_W), .TOT_W(F_TOT_W)) u_fport (
      .clk      (clk),
      .rst      (rst),
      .beat     (beat_f_c),
      .total    (f_tot_c),
      .wdata_in (gb_data),
      .we       (fspad_we),
      .addr     (fspad_addr),
      .wdata    (fspad_wdata),
      .last_c   (last_f_c)
   );

   spad_write_port #(.DATA_W(DATA_W), .ADDR_W(IADDR_W), .TOT_W(I_TOT_W)) u_iport (
      .clk      (clk),
      .rst      (rst),
      .beat     (beat_i_c),
      .total    (i_tot_c),
      .wdata_in (gb_data),
      .we       (ispad_we),
      .addr     (ispad_addr),
      .wdata    (ispad_wdata),
      .last_c   (last_i_c)
   );

   always_comb begin
      state_d    = state_q;
      oc_d       = oc_q;
      ic_d       = ic_q;
      fw_d       = fw_q;
      err_d      = 1'b0;
      complete_d = complete_q;
      wdog_d     = wdog_q;

      case (state_q)
         S_IDLE: begin
            if (cfg_go) begin
               oc_d = oc;
               ic_d = ic;
               fw_d = filter_width;
               if (cfg_ok_c) state_d = S_LOAD_F;
               else          err_d   = 1'b1;
            end
         end
         S_LOAD_F: if (last_f_c) state_d = S_LOAD_I;
         S_LOAD_I: if (last_i_c) state_d = S_FLUSH;
         S_FLUSH:  state_d = S_START;
         S_START: begin
            // Arm edge detection so a complete already high is not taken as an edge.
            complete_d = complete;
            wdog_d     = '0;
            state_d    = S_RUN;
         end
         S_RUN: begin
            complete_d = complete;
            if (cplt_edge_c) begin
               state_d = S_DONE;
            end else if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         S_DONE: begin
            wdog_d  = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      gb_ready_d = (state_d == S_LOAD_F) || (state_d == S_LOAD_I);
      load_d     = (state_d == S_LOAD_F) || (state_d == S_LOAD_I) || (state_d == S_FLUSH);
      start_d    = (state_d == S_RUN);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         oc_q       <= '0;
         ic_q       <= '0;
         fw_q       <= '0;
         gb_ready_q <= 1'b0;
         load_q     <= 1'b0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         complete_q <= 1'b0;
         wdog_q     <= '0;
      end else begin
         state_q    <= state_d;
         oc_q       <= oc_d;
         ic_q       <= ic_d;
         fw_q       <= fw_d;
         gb_ready_q <= gb_ready_d;
         load_q     <= load_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         complete_q <= complete_d;
         wdog_q     <= wdog_d;
      end
   end

   assign gb_ready = gb_ready_q;
   assign load     = load_q;
   assign start    = start_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule
